// File: rtl/cbrt_sched.sv
// Issue/collect stage for the cube-root unit: operand FIFO, start/busy sequencing, result pair output.
// Optional result self-check is enabled by defining CBRT_SCHED_CHECK_EN.
module cbrt_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_x_bi,
    output logic [7:0] cbrt_x_bo,
    output logic       cbrt_start_o,
    input  logic       cbrt_busy_i,
    input  logic [2:0] cbrt_res_bi,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_x_bo,
    output logic [2:0] out_y_bo,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t state_q, state_d;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic [7:0] cbrtX_q;
    logic [7:0] hx_q;
    logic [7:0] outX_q;
    logic [2:0] outY_q;
    logic       outValid_q;

    logic push;
    logic pop;
    logic issueGo;
    logic capture;

    assign in_ready_o   = (cnt_q != FULL_CNT);
    assign push         = in_valid_i && in_ready_o;
    assign pop          = (state_q == ISSUE);
    assign cbrt_start_o = (state_q == ISSUE) && !rst_i;
    assign cbrt_x_bo    = cbrtX_q;
    assign out_valid_o  = outValid_q;
    assign out_x_bo     = outX_q;
    assign out_y_bo     = outY_q;

    always_comb begin
        state_d = state_q;
        issueGo = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0 && !outValid_q && !cbrt_busy_i) begin
                    state_d = ISSUE;
                    issueGo = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: if (cbrt_busy_i) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!cbrt_busy_i) begin
                    state_d = IDLE;
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        cnt_d   = cnt_q;
        if (push) wrPtr_d = wrPtr_q + 1'b1;
        if (pop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: emptiness is tracked entirely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wrPtr_q] <= in_x_bi;
    end

    // The head is loaded on the IDLE->ISSUE edge so the operand is stable while start is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cbrtX_q    <= '0;
            hx_q       <= '0;
            outX_q     <= '0;
            outY_q     <= '0;
            outValid_q <= 1'b0;
        end else begin
            if (issueGo) begin
                cbrtX_q <= mem_q[rdPtr_q];
                hx_q    <= mem_q[rdPtr_q];
            end
            if (capture) begin
                outX_q     <= hx_q;
                outY_q     <= cbrt_res_bi;
                outValid_q <= 1'b1;
            end else if (outValid_q && out_ready_i) begin
                outValid_q <= 1'b0;
            end
        end
    end

`ifdef CBRT_SCHED_CHECK_EN
    logic [9:0] yExt;
    logic [9:0] y1Ext;
    logic [9:0] xExt;
    logic [9:0] loCube;
    logic [9:0] hiCube;
    logic       inRange;
    logic       err_q;

    // Cubes of 0..8 fit in 10 bits, so the truncated products are exact.
    always_comb begin
        yExt    = {7'd0, cbrt_res_bi};
        y1Ext   = yExt + 10'd1;
        xExt    = {2'b00, hx_q};
        loCube  = yExt * yExt * yExt;
        hiCube  = y1Ext * y1Ext * y1Ext;
        inRange = (loCube <= xExt) && (xExt < hiCube);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)                   err_q <= 1'b0;
        else if (capture && !inRange) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cbrt_sched.sv
// Directed self-checking bench for cbrt_sched with a behavioural cube-root unit model.
module tb_cbrt_sched;

    localparam int MODEL_LAT = 3;
`ifdef CBRT_SCHED_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       inReady;
    logic [7:0] inX;
    logic [7:0] cbrtX;
    logic       cbrtStart;
    logic       cbrtBusy;
    logic [2:0] cbrtRes;
    logic       outValid;
    logic       outReady;
    logic [7:0] outX;
    logic [2:0] outY;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic       modelBusy;
    logic       holdBusy;
    logic       faultyModel;
    logic [7:0] modelX;
    int         modelLat;
    int         startCount;
    logic [7:0] lastStartX;
    logic [10:0] pairQ[$];

    cbrt_sched #(.DEPTH(4), .AW(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_x_bi     (inX),
        .cbrt_x_bo   (cbrtX),
        .cbrt_start_o(cbrtStart),
        .cbrt_busy_i (cbrtBusy),
        .cbrt_res_bi (cbrtRes),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_x_bo    (outX),
        .out_y_bo    (outY),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cbrtBusy = modelBusy || holdBusy;

    function automatic logic [2:0] modelCbrt(input logic [7:0] x, input logic faulty);
        int y;
        y = 0;
        while ((y + 1) * (y + 1) * (y + 1) <= int'(x)) y++;
        if (faulty && x == 8'd27) y = 4;
        return y[2:0];
    endfunction

    // Cube-root unit model: latches x on start, busy from the next cycle, result valid when busy falls.
    always @(posedge clk) begin
        if (rst) begin
            modelBusy <= 1'b0;
            modelLat  <= 0;
            cbrtRes   <= 3'd0;
        end else if (!modelBusy && cbrtStart) begin
            modelX    <= cbrtX;
            modelBusy <= 1'b1;
            modelLat  <= MODEL_LAT;
        end else if (modelBusy) begin
            if (modelLat == 0) begin
                modelBusy <= 1'b0;
                cbrtRes   <= modelCbrt(modelX, faultyModel);
            end else begin
                modelLat <= modelLat - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && cbrtStart) begin
            startCount <= startCount + 1;
            lastStartX <= cbrtX;
        end
        if (!rst && outValid && outReady) pairQ.push_back({outX, outY});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x);
        int waited;
        waited = 0;
        while (!inReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) checkOutput("push_timeout", 32'd0, 32'd1);
        inValid = 1'b1;
        inX     = x;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitPairs(input int n, input string tag);
        for (int i = 0; i < 400 && pairQ.size() < n; i++) @(negedge clk);
        checkOutput({tag, "_count"}, pairQ.size(), n);
    endtask

    task automatic checkPair(input int idx, input logic [7:0] x, input logic [2:0] y, input string tag);
        logic [31:0] obs;
        obs = (idx < pairQ.size()) ? {21'd0, pairQ[idx]} : 32'hFFFF;
        checkOutput(tag, obs, {21'd0, x, y});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int bad;
        logic [7:0] seqX [5];
        logic [2:0] seqY [5];
        seqX = '{8'd0, 8'd1, 8'd8, 8'd255, 8'd7};
        seqY = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd1};

        rst = 1'b1; inValid = 1'b0; inX = 8'd0; outReady = 1'b1;
        holdBusy = 1'b0; faultyModel = 1'b0; startCount = 0; lastStartX = 8'd0;
        modelX = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_x", outX, 0);
        checkOutput("rst_out_y", outY, 0);
        checkOutput("rst_cbrt_x", cbrtX, 0);
        checkOutput("rst_start", cbrtStart, 0);
        checkOutput("rst_err", err, 0);

        // Single operand
        applyStimulus(8'd27);
        waitPairs(1, "single");
        checkPair(0, 8'd27, 3'd3, "single_pair");
        repeat (10) @(negedge clk);
        checkOutput("single_starts", startCount, 1);
        checkOutput("single_start_x", lastStartX, 27);
        checkOutput("single_err", err, 0);

        // Back-to-back sequence, issue held off so the FIFO fills
        pairQ.delete();
        holdBusy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(seqX[i]);
        checkOutput("seq_full_ready", inReady, 0);
        holdBusy = 1'b0;
        for (int i = 0; i < 50 && !inReady; i++) @(negedge clk);
        checkOutput("seq_ready_back", inReady, 1);
        applyStimulus(seqX[4]);
        waitPairs(5, "seq");
        for (int i = 0; i < 5; i++) checkPair(i, seqX[i], seqY[i], $sformatf("seq_pair%0d", i));

        // Downstream stall with two operands queued
        pairQ.delete();
        outReady = 1'b0;
        applyStimulus(8'd64);
        applyStimulus(8'd125);
        for (int i = 0; i < 100 && !outValid; i++) @(negedge clk);
        checkOutput("stall_valid", outValid, 1);
        s0  = startCount;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (outValid !== 1'b1 || outX !== 8'd64 || outY !== 3'd4) bad++;
        end
        checkOutput("stall_stable", bad, 0);
        checkOutput("stall_no_start", startCount, s0);
        outReady = 1'b1;
        waitPairs(2, "stall");
        checkPair(0, 8'd64, 3'd4, "stall_pair0");
        checkPair(1, 8'd125, 3'd5, "stall_pair1");

        // Push coinciding with the pop of a single queued entry
        pairQ.delete();
        applyStimulus(8'd100);
        for (int i = 0; i < 50 && !cbrtStart; i++) @(negedge clk);
        checkOutput("pp_start_seen", cbrtStart, 1);
        inValid = 1'b1;
        inX     = 8'd200;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("pp_count", dut.cnt_q, 1);
        waitPairs(2, "pp");
        checkPair(0, 8'd100, 3'd4, "pp_pair0");
        checkPair(1, 8'd200, 3'd5, "pp_pair1");
        repeat (30) @(negedge clk);
        checkOutput("pp_no_extra", pairQ.size(), 2);

        // Reset during WAIT_LO with three operands queued
        pairQ.delete();
        applyStimulus(8'd27);
        applyStimulus(8'd64);
        applyStimulus(8'd125);
        applyStimulus(8'd216);
        for (int i = 0; i < 50 && !cbrtBusy; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("mid_busy", cbrtBusy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_out_valid", outValid, 0);
        checkOutput("mid_in_ready", inReady, 1);
        checkOutput("mid_count", dut.cnt_q, 0);
        s0 = startCount;
        repeat (30) @(negedge clk);
        checkOutput("mid_no_pairs", pairQ.size(), 0);
        checkOutput("mid_no_start", startCount, s0);

        // Faulty cube-root result
        pairQ.delete();
        faultyModel = 1'b1;
        applyStimulus(8'd27);
        waitPairs(1, "err");
        checkPair(0, 8'd27, 3'd4, "err_pair");
        checkOutput("err_flag", err, EXP_ERR);
        repeat (10) @(negedge clk);
        checkOutput("err_sticky", err, EXP_ERR);
        faultyModel = 1'b0;
        resetDut();
        checkOutput("err_cleared", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
